// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encodings and default prescaler divide
//
// Purpose: common definitions for the stopwatch control block.
//   state_t          : 2-bit FSM encoding IDLE=0, RUN=1, STOP=2, LAP=3
//   TICK_DIV_DEFAULT : clock cycles per hundredth-second increment
package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2,
    S_LAP  = 2'd3
  } state_t;

  localparam int TICK_DIV_DEFAULT = 1000000;

endpackage

// File: rtl/press_detect.sv
// rtl/press_detect.sv - rising-edge press pulse from a clean button level
//
// Purpose: registers the previous button level and flags the first cycle
// the button is seen high, so a held button yields exactly one press.
// Ports:
//   clock : system clock
//   reset : synchronous active-high reset, clears the history bit
//   btn   : synchronised, debounced button level
//   press : combinational pulse, btn & ~previous btn
module press_detect (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      prev <= 1'b0;
    end else begin
      prev <= btn;
    end
  end

  assign press = btn & ~prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch run/stop/lap/clear FSM with hundredths prescaler
//
// Purpose: turns start/stop and lap/reset button presses into control for
// the digit counter chain and display latch.
// Ports:
//   clock   : system clock
//   reset   : synchronous active-high reset
//   btn_ss  : start/stop button level (synchronised, debounced)
//   btn_lr  : lap/reset button level (synchronised, debounced)
//   inc     : one-cycle pulse advancing the hundredths digit
//   clr     : one-cycle pulse clearing the digit counters
//   hold    : display freeze level, high while in LAP
//   running : high in RUN or LAP
//   state   : current FSM state (IDLE=0, RUN=1, STOP=2, LAP=3)
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int TICK_W   = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic       inc,
  output logic       clr,
  output logic       hold,
  output logic       running,
  output logic [1:0] state
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

  logic              press_ss;
  logic              press_lr;
  state_t            cur;
  state_t            nxt;
  logic [TICK_W-1:0] presc;
  logic              counting;
  logic              wrap;

  press_detect u_press_ss (
    .clock (clock),
    .reset (reset),
    .btn   (btn_ss),
    .press (press_ss)
  );

  press_detect u_press_lr (
    .clock (clock),
    .reset (reset),
    .btn   (btn_lr),
    .press (press_lr)
  );

  // Start/stop is checked first everywhere, so a same-edge lap/reset
  // press is dropped.
  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE: if (press_ss) nxt = S_RUN;
      S_RUN: begin
        if (press_ss)      nxt = S_STOP;
        else if (press_lr) nxt = S_LAP;
      end
      S_LAP: begin
        if (press_ss)      nxt = S_STOP;
        else if (press_lr) nxt = S_RUN;
      end
      S_STOP: begin
        if (press_ss)      nxt = S_RUN;
        else if (press_lr) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Counting follows the current state, so the edge that leaves RUN/LAP
  // still counts and can still produce its final inc.
  assign counting = (cur == S_RUN) || (cur == S_LAP);
  assign wrap     = counting && (presc == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      cur     <= S_IDLE;
      presc   <= '0;
      inc     <= 1'b0;
      clr     <= 1'b0;
      hold    <= 1'b0;
      running <= 1'b0;
    end else begin
      cur     <= nxt;
      inc     <= wrap;
      clr     <= (cur == S_STOP) && (nxt == S_IDLE);
      hold    <= (nxt == S_LAP);
      running <= (nxt == S_RUN) || (nxt == S_LAP);
      // STOP keeps the partial count so a resume finishes the same tick.
      if (wrap) begin
        presc <= '0;
      end else if (counting) begin
        presc <= presc + TICK_W'(1);
      end else if (nxt == S_IDLE) begin
        presc <= '0;
      end
    end
  end

  assign state = cur;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM for the stopwatch digit chain. It turns the start/stop and lap/reset buttons into run, pause, lap-hold and clear control. It owns the hundredths prescaler and emits the single-cycle `inc` strobe that drives the least-significant digit counter, whose carries feed the mod-10/mod-6 stages. It sits between the synchronised button inputs and the counter/display chain.

Parameters:
- TICK_DIV, 1000000, clock cycles per hundredth-second `inc`; legal range 2..2^TICK_W.
- TICK_W, 20, prescaler width; must hold TICK_DIV-1.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_ss  input  1  start/stop button level, already synchronised and debounced.
- btn_lr  input  1  lap/reset button level, already synchronised and debounced.
- inc  output  1  one-cycle pulse; increments the hundredths digit counter.
- clr  output  1  one-cycle pulse; drives the digit counters' reset input.
- hold  output  1  level; the display latch freezes while this is 1.
- running  output  1  level; 1 in RUN or LAP.
- state  output  2  current FSM state: IDLE=0, RUN=1, STOP=2, LAP=3.

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous and active-high. On any edge with reset=1: state=IDLE, prescaler=0, both edge-detect history bits=0, inc=0, clr=0, hold=0, running=0.
  - Reset overrides every other event, including mid-count and mid-press.
- Press detection: press_x = btn_x & ~prev_x, with prev_x registered every edge. A held button gives exactly one press.
- Simultaneous presses: if ss and lr presses occur on the same edge, ss wins and the lr press is discarded.
- Transitions (evaluated on each edge, using the press flags):
  - IDLE: ss -> RUN. lr is ignored.
  - RUN: ss -> STOP. lr -> LAP.
  - LAP: lr -> RUN (releases hold). ss -> STOP (releases hold).
  - STOP: ss -> RUN. lr -> IDLE, and clr=1 for the following cycle.
- Prescaler:
  - Increments on each edge where the current state is RUN or LAP.
  - On an edge where it equals TICK_DIV-1 and the state is RUN/LAP, it wraps to 0 and the inc register is set, so inc=1 for exactly the next cycle.
  - In STOP it holds its value, preserving the sub-tick fraction.
  - It is forced to 0 on entry to IDLE.
- inc timing:
  - The first inc is high in the cycle after the TICK_DIV-th edge following entry to RUN from IDLE.
  - A wrap on the same edge as a RUN->STOP transition still produces that inc.
  - inc is never high in IDLE.
- Outputs: all are registered. hold=1 exactly while state=LAP. running = (state==RUN || state==LAP).
- clr: asserted only on the STOP->IDLE path. inc and clr are never high in the same cycle.

Decomposition:
- Shared package stopwatch_pkg: 2-bit state encodings IDLE/RUN/STOP/LAP and the default TICK_DIV constant.
- One sub-module, press_detect (register plus rising-edge pulse), instantiated once per button.
- The prescaler and FSM stay in stopwatch_ctrl.

Test Plan (TICK_DIV=4):
- Reset: hold reset 3 cycles, release -> state=0 and inc/clr/hold/running=0; no inc over the next 20 cycles.
- Run cadence: pulse btn_ss 1 cycle -> state=1 next cycle; inc high every 4th cycle, first inc 4 cycles after entry; 10 incs over 40 cycles.
- Pause/resume fraction: stop after 2 prescaler counts, wait 10 cycles (no inc), restart -> first inc 2 cycles after re-entry to RUN.
- Lap: in RUN press btn_lr -> state=3, hold=1, inc cadence unchanged; press btn_lr again -> state=1, hold=0.
- Clear: in STOP press btn_lr -> state=0, clr=1 for exactly 1 cycle, prescaler=0; hold btn_lr high 10 cycles -> only one clr.
- Simultaneous press: in RUN raise btn_ss and btn_lr on the same cycle -> state=2, hold=0; assert reset mid-LAP -> state=0, hold=0 the next cycle.
